// File: rtl/lsu_demux_pkg.sv
// Shared types for the LSU 1-to-3 request router.
package lsu_demux_pkg;

    localparam int unsigned NUM_TGT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TGT0     = 2'd0,
        TGT1     = 2'd1,
        TGT2     = 2'd2,
        TGT_NONE = 2'd3
    } tgt_t;

    // One-hot lane mask for a target; TGT_NONE maps to no lane.
    function automatic logic [NUM_TGT-1:0] tgt_onehot(input tgt_t t);
        logic [NUM_TGT-1:0] oh;
        oh = '0;
        case (t)
            TGT0:    oh = 3'b001;
            TGT1:    oh = 3'b010;
            TGT2:    oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/lsu_addr_decode3.sv
// Base/mask address decoder over three windows, lowest index wins.
module lsu_addr_decode3
    import lsu_demux_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  T0_BASE    = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0]  T0_MASK    = ADDR_WIDTH'(32'hFFFF_C000),
    parameter logic [ADDR_WIDTH-1:0]  T1_BASE    = ADDR_WIDTH'(32'h1000_0000),
    parameter logic [ADDR_WIDTH-1:0]  T1_MASK    = ADDR_WIDTH'(32'hFFFF_F000),
    parameter logic [ADDR_WIDTH-1:0]  T2_BASE    = ADDR_WIDTH'(32'h2000_0000),
    parameter logic [ADDR_WIDTH-1:0]  T2_MASK    = ADDR_WIDTH'(32'hFFFF_0000)
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output tgt_t                  o_tgt_c
);

    // Priority compare: earlier windows shadow later ones on overlap.
    always_comb begin
        o_tgt_c = TGT_NONE;
        if ((i_addr & T0_MASK) == T0_BASE) begin
            o_tgt_c = TGT0;
        end else if ((i_addr & T1_MASK) == T1_BASE) begin
            o_tgt_c = TGT1;
        end else if ((i_addr & T2_MASK) == T2_BASE) begin
            o_tgt_c = TGT2;
        end
    end

endmodule

// File: rtl/lsu_demux3.sv
// LSU request router: one outstanding request steered to one of three
// targets, with error completion for unmapped addresses and timeouts.
module lsu_demux3
    import lsu_demux_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter int unsigned            ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]  T0_BASE        = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0]  T0_MASK        = ADDR_WIDTH'(32'hFFFF_C000),
    parameter logic [ADDR_WIDTH-1:0]  T1_BASE        = ADDR_WIDTH'(32'h1000_0000),
    parameter logic [ADDR_WIDTH-1:0]  T1_MASK        = ADDR_WIDTH'(32'hFFFF_F000),
    parameter logic [ADDR_WIDTH-1:0]  T2_BASE        = ADDR_WIDTH'(32'h2000_0000),
    parameter logic [ADDR_WIDTH-1:0]  T2_MASK        = ADDR_WIDTH'(32'hFFFF_0000),
    parameter int unsigned            TIMEOUT_CYCLES = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  logic [ADDR_WIDTH-1:0]           i_req_addr,
    input  logic                            i_req_we,
    input  logic [DATA_WIDTH-1:0]           i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]         i_req_be,
    output logic                            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]           o_rsp_rdata,
    output logic                            o_rsp_err,
    output logic [NUM_TGT-1:0]              o_t_valid,
    input  logic [NUM_TGT-1:0]              i_t_ready,
    output logic [ADDR_WIDTH-1:0]           o_t_addr,
    output logic                            o_t_we,
    output logic [DATA_WIDTH-1:0]           o_t_wdata,
    output logic [DATA_WIDTH/8-1:0]         o_t_be,
    input  logic [NUM_TGT-1:0]              i_t_rsp_valid,
    input  logic [NUM_TGT*DATA_WIDTH-1:0]   i_t_rdata
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    // One spare bit: a handshake on the last budget cycle lets the count
    // step one past the limit before the WAIT check fires.
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                 state_q, state_d;
    tgt_t                   sel_q, sel_d;
    logic [NUM_TGT-1:0]     t_valid_q, t_valid_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;

    tgt_t                   dec_tgt;
    logic [NUM_TGT-1:0]     sel_oh;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic                   hs;
    logic                   rsp_hit;
    logic                   expired;

    lsu_addr_decode3 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .T0_BASE    (T0_BASE),
        .T0_MASK    (T0_MASK),
        .T1_BASE    (T1_BASE),
        .T1_MASK    (T1_MASK),
        .T2_BASE    (T2_BASE),
        .T2_MASK    (T2_MASK)
    ) u_decode (
        .i_addr  (i_req_addr),
        .o_tgt_c (dec_tgt)
    );

    // Read-data lane of the currently selected target.
    always_comb begin
        sel_rdata = '0;
        case (sel_q)
            TGT0:    sel_rdata = i_t_rdata[0            +: DATA_WIDTH];
            TGT1:    sel_rdata = i_t_rdata[DATA_WIDTH   +: DATA_WIDTH];
            TGT2:    sel_rdata = i_t_rdata[2*DATA_WIDTH +: DATA_WIDTH];
            default: sel_rdata = '0;
        endcase
    end

    assign sel_oh  = tgt_onehot(sel_q);
    assign hs      = |(i_t_ready & sel_oh);
    assign rsp_hit = |(i_t_rsp_valid & sel_oh);
    assign expired = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, payload capture, timeout and response formation.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        t_valid_d   = t_valid_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    we_d    = i_req_we;
                    wdata_d = i_req_wdata;
                    be_d    = i_req_be;
                    sel_d   = dec_tgt;
                    if (dec_tgt == TGT_NONE) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = REQ;
                        t_valid_d = tgt_onehot(dec_tgt);
                        cnt_d     = '0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (hs) begin
                    state_d   = WAIT;
                    t_valid_d = '0;
                end else if (expired) begin
                    state_d     = RSP;
                    t_valid_d   = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (rsp_hit) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : sel_rdata;
                    rsp_err_d   = 1'b0;
                end else if (expired) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sel_q       <= TGT0;
            t_valid_q   <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            t_valid_q   <= t_valid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_t_valid   = t_valid_q;
    assign o_t_addr    = addr_q;
    assign o_t_we      = we_q;
    assign o_t_wdata   = wdata_q;
    assign o_t_be      = be_q;

endmodule
